// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit_pkg : ALU_Op, funct and ALUctrl encodings (rev 1.0)    |
// +----------------------------------------------------------------------+
package alu_exec_unit_pkg;

  localparam logic [2:0] C_OP_ADD  = 3'b000;
  localparam logic [2:0] C_OP_SUB  = 3'b001;
  localparam logic [2:0] C_OP_RTYP = 3'b010;
  localparam logic [2:0] C_OP_AND  = 3'b011;
  localparam logic [2:0] C_OP_OR   = 3'b100;
  localparam logic [2:0] C_OP_SLT  = 3'b101;
  localparam logic [2:0] C_OP_LUI  = 3'b110;
  localparam logic [2:0] C_OP_ADD2 = 3'b111;

  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_NOR = 6'b100111;
  localparam logic [5:0] C_FN_SLT = 6'b101010;
  localparam logic [5:0] C_FN_SLL = 6'b000000;
  localparam logic [5:0] C_FN_SRL = 6'b000010;
  localparam logic [5:0] C_FN_JR  = 6'b001000;

  localparam logic [3:0] C_CTL_AND = 4'b0000;
  localparam logic [3:0] C_CTL_OR  = 4'b0001;
  localparam logic [3:0] C_CTL_ADD = 4'b0010;
  localparam logic [3:0] C_CTL_SLL = 4'b0011;
  localparam logic [3:0] C_CTL_SRL = 4'b0100;
  localparam logic [3:0] C_CTL_LUI = 4'b0101;
  localparam logic [3:0] C_CTL_SUB = 4'b0110;
  localparam logic [3:0] C_CTL_SLT = 4'b0111;
  localparam logic [3:0] C_CTL_NOR = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decoder : ALU_Op/funct -> ALUctrl and JR flag (rev 1.0)          |
// +----------------------------------------------------------------------+
module alu_decoder
  import alu_exec_unit_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_jr
);

  always_comb begin
    o_alu_ctrl = C_CTL_ADD;
    o_jr       = 1'b0;
    case (i_alu_op)
      C_OP_ADD:  o_alu_ctrl = C_CTL_ADD;
      C_OP_SUB:  o_alu_ctrl = C_CTL_SUB;
      C_OP_AND:  o_alu_ctrl = C_CTL_AND;
      C_OP_OR:   o_alu_ctrl = C_CTL_OR;
      C_OP_SLT:  o_alu_ctrl = C_CTL_SLT;
      C_OP_LUI:  o_alu_ctrl = C_CTL_LUI;
      C_OP_ADD2: o_alu_ctrl = C_CTL_ADD;
      C_OP_RTYP: begin
        case (i_funct)
          C_FN_ADD: o_alu_ctrl = C_CTL_ADD;
          C_FN_SUB: o_alu_ctrl = C_CTL_SUB;
          C_FN_AND: o_alu_ctrl = C_CTL_AND;
          C_FN_OR:  o_alu_ctrl = C_CTL_OR;
          C_FN_NOR: o_alu_ctrl = C_CTL_NOR;
          C_FN_SLT: o_alu_ctrl = C_CTL_SLT;
          C_FN_SLL: o_alu_ctrl = C_CTL_SLL;
          C_FN_SRL: o_alu_ctrl = C_CTL_SRL;
          // JR passes rs through the adder; the flag steers the PC mux
          C_FN_JR: begin
            o_alu_ctrl = C_CTL_ADD;
            o_jr       = 1'b1;
          end
          default:  o_alu_ctrl = C_CTL_ADD;
        endcase
      end
      default:   o_alu_ctrl = C_CTL_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit : decode + 32-bit ALU + branch adder, registered (1.0) |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        in_valid,
  input  logic [2:0]  ALU_Op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] imm_ext,
  input  logic [31:0] pc_plus4,
  output logic        out_valid,
  output logic [3:0]  ALUctrl,
  output logic        JR_Signal,
  output logic [31:0] Alu_Result,
  output logic        Zero,
  output logic [31:0] branch_target
);

  logic [3:0]  w_alu_ctrl;
  logic        w_jr;
  logic [31:0] w_result;
  logic [31:0] w_branch;

  alu_decoder u_dec (
    .i_alu_op   (ALU_Op),
    .i_funct    (funct),
    .o_alu_ctrl (w_alu_ctrl),
    .o_jr       (w_jr)
  );

  always_comb begin
    w_result = 32'h0;
    case (w_alu_ctrl)
      C_CTL_AND: w_result = A & B;
      C_CTL_OR:  w_result = A | B;
      C_CTL_ADD: w_result = A + B;
      C_CTL_SUB: w_result = A - B;
      C_CTL_NOR: w_result = ~(A | B);
      C_CTL_SLT: w_result = {31'h0, ($signed(A) < $signed(B))};
      C_CTL_SLL: w_result = B << shamt;
      C_CTL_SRL: w_result = B >> shamt;
      C_CTL_LUI: w_result = {B[15:0], 16'h0000};
      default:   w_result = 32'h0;
    endcase
  end

  assign w_branch = pc_plus4 + {imm_ext[29:0], 2'b00};

  // Zero is its own flop so it reads 0 during reset even though the result is 0
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid     <= 1'b0;
      ALUctrl       <= C_CTL_AND;
      JR_Signal     <= 1'b0;
      Alu_Result    <= 32'h0;
      Zero          <= 1'b0;
      branch_target <= 32'h0;
    end else begin
      out_valid     <= in_valid;
      ALUctrl       <= w_alu_ctrl;
      JR_Signal     <= w_jr;
      Alu_Result    <= w_result;
      Zero          <= (w_result == 32'h0);
      branch_target <= w_branch;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_exec_unit : table-driven scoreboard bench (rev 1.0)           |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

  typedef struct packed {
    logic        vld;
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  e_ctl;
    logic        e_jr;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_bt;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  ALU_Op = 3'b0;
  logic [5:0]  funct = 6'b0;
  logic [4:0]  shamt = 5'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] imm_ext = 32'h0;
  logic [31:0] pc_plus4 = 32'h0;
  logic        out_valid;
  logic [3:0]  ALUctrl;
  logic        JR_Signal;
  logic [31:0] Alu_Result;
  logic        Zero;
  logic [31:0] branch_target;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv [20];
  vec_t sb [$];

  always #5 Clock = ~Clock;

  alu_exec_unit dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .in_valid      (in_valid),
    .ALU_Op        (ALU_Op),
    .funct         (funct),
    .shamt         (shamt),
    .A             (A),
    .B             (B),
    .imm_ext       (imm_ext),
    .pc_plus4      (pc_plus4),
    .out_valid     (out_valid),
    .ALUctrl       (ALUctrl),
    .JR_Signal     (JR_Signal),
    .Alu_Result    (Alu_Result),
    .Zero          (Zero),
    .branch_target (branch_target)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.vld;
    ALU_Op   = v.op;
    funct    = v.fn;
    shamt    = v.sh;
    A        = v.a;
    B        = v.b;
    imm_ext  = v.imm;
    pc_plus4 = v.pc;
    sb.push_back(v);
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'h1, 32'h0);
      return;
    end
    e = sb.pop_front();
    check({tag, " out_valid"},  {31'h0, out_valid},  {31'h0, e.vld});
    check({tag, " ALUctrl"},    {28'h0, ALUctrl},    {28'h0, e.e_ctl});
    check({tag, " JR_Signal"},  {31'h0, JR_Signal},  {31'h0, e.e_jr});
    check({tag, " Alu_Result"}, Alu_Result,          e.e_res);
    check({tag, " Zero"},       {31'h0, Zero},       {31'h0, e.e_zero});
    check({tag, " branch"},     branch_target,       e.e_bt);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " out_valid"},  {31'h0, out_valid}, 32'h0);
    check({tag, " ALUctrl"},    {28'h0, ALUctrl},   32'h0);
    check({tag, " JR_Signal"},  {31'h0, JR_Signal}, 32'h0);
    check({tag, " Alu_Result"}, Alu_Result,         32'h0);
    check({tag, " Zero"},       {31'h0, Zero},      32'h0);
    check({tag, " branch"},     branch_target,      32'h0);
  endtask

  initial begin
    //          vld op      fn         sh  a             b             imm           pc            ctl      jr  res           z   bt
    tv[0]  = '{1'b1, 3'b000, 6'b000000, 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00400004, 4'b0010, 1'b0, 32'h80000000, 1'b0, 32'h00400000};
    tv[1]  = '{1'b1, 3'b000, 6'b000000, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000010, 32'h00400004, 4'b0010, 1'b0, 32'h00000000, 1'b1, 32'h00400044};
    tv[2]  = '{1'b1, 3'b001, 6'b000000, 5'd0, 32'h00001234, 32'h00001234, 32'h00000001, 32'h00000100, 4'b0110, 1'b0, 32'h00000000, 1'b1, 32'h00000104};
    tv[3]  = '{1'b1, 3'b010, 6'b100100, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b0000, 1'b0, 32'h00F000F0, 1'b0, 32'h00000104};
    tv[4]  = '{1'b1, 3'b010, 6'b100101, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b0001, 1'b0, 32'hFFF0FFF0, 1'b0, 32'h00000104};
    tv[5]  = '{1'b1, 3'b010, 6'b100111, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b1100, 1'b0, 32'h000F000F, 1'b0, 32'h00000104};
    tv[6]  = '{1'b1, 3'b010, 6'b000000, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b0011, 1'b0, 32'hFF00FF00, 1'b0, 32'h00000104};
    tv[7]  = '{1'b1, 3'b010, 6'b000010, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b0100, 1'b0, 32'h00FF00FF, 1'b0, 32'h00000104};
    tv[8]  = '{1'b1, 3'b010, 6'b101010, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000001, 32'h00000100, 4'b0111, 1'b0, 32'h00000001, 1'b0, 32'h00000104};
    tv[9]  = '{1'b1, 3'b010, 6'b100010, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000002, 32'h00000100, 4'b0110, 1'b0, 32'hE100E100, 1'b0, 32'h00000108};
    tv[10] = '{1'b1, 3'b010, 6'b100000, 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000002, 32'h00000100, 4'b0010, 1'b0, 32'h00E100E0, 1'b0, 32'h00000108};
    tv[11] = '{1'b1, 3'b010, 6'b001000, 5'd0, 32'h00400000, 32'h00000000, 32'h00000000, 32'h00001000, 4'b0010, 1'b1, 32'h00400000, 1'b0, 32'h00001000};
    tv[12] = '{1'b1, 3'b000, 6'b001000, 5'd0, 32'h00000005, 32'h00000006, 32'h00000000, 32'h00001000, 4'b0010, 1'b0, 32'h0000000B, 1'b0, 32'h00001000};
    tv[13] = '{1'b1, 3'b010, 6'b111111, 5'd0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00001000, 4'b0010, 1'b0, 32'h00000007, 1'b0, 32'h00001000};
    tv[14] = '{1'b1, 3'b011, 6'b100000, 5'd0, 32'hFF00FF00, 32'h0000FFFF, 32'h00000000, 32'h00001000, 4'b0000, 1'b0, 32'h0000FF00, 1'b0, 32'h00001000};
    tv[15] = '{1'b1, 3'b100, 6'b100000, 5'd0, 32'h12340000, 32'h00005678, 32'h00000000, 32'h00001000, 4'b0001, 1'b0, 32'h12345678, 1'b0, 32'h00001000};
    tv[16] = '{1'b1, 3'b101, 6'b101010, 5'd0, 32'h00000005, 32'hFFFFFFFF, 32'h00000000, 32'h00001000, 4'b0111, 1'b0, 32'h00000000, 1'b1, 32'h00001000};
    tv[17] = '{1'b1, 3'b110, 6'b000000, 5'd0, 32'hDEADBEEF, 32'h0000ABCD, 32'h00000000, 32'h00001000, 4'b0101, 1'b0, 32'hABCD0000, 1'b0, 32'h00001000};
    tv[18] = '{1'b1, 3'b111, 6'b000000, 5'd0, 32'h00000001, 32'h00000002, 32'hFFFFFFFE, 32'h00000010, 4'b0010, 1'b0, 32'h00000003, 1'b0, 32'h00000008};
    tv[19] = '{1'b0, 3'b000, 6'b000000, 5'd0, 32'h00000002, 32'h00000002, 32'h00000000, 32'h00000000, 4'b0010, 1'b0, 32'h00000004, 1'b0, 32'h00000000};

    // Reset held across edges with busy inputs: everything stays cleared
    in_valid = 1'b1; ALU_Op = 3'b010; funct = 6'b001000; A = 32'h55; B = 32'h1;
    pc_plus4 = 32'h40; imm_ext = 32'h3;
    repeat (2) @(posedge Clock);
    #1;
    check_cleared("reset");

    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(tv[i]);
      @(posedge Clock);
      #1;
      pop_check($sformatf("vec%0d", i));
    end

    // Mid-stream reset: async clear, in-flight result discarded
    drive(tv[0]);
    @(posedge Clock);
    #1;
    pop_check("pre_rst");
    drive(tv[15]);
    #2;
    Reset_n = 1'b0;
    #1;
    check_cleared("async_rst");
    sb.delete();
    @(posedge Clock);
    #1;
    check_cleared("rst_hold");
    Reset_n = 1'b1;
    drive(tv[17]);
    @(posedge Clock);
    #1;
    pop_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block for the single-cycle MIPS datapath, with its outputs registered. It combines three functions:
- decoding of the controller's 3-bit ALU opcode and the instruction funct field into an ALU operation and a jump-register flag;
- the 32-bit ALU with its zero flag;
- the branch-target adder.

It sits between the register-file/sign-extend stage and the data-memory/PC-select logic. Its results feed the data-memory address, the write-back mux, the beq/bne gating and the JR mux.

## Interface
Reset is asynchronous and active-low; there is one clock. There are no parameters.
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands are valid this cycle
- ALU_Op  in  3  controller opcode
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- A  in  32  Read_Data_1 (rs)
- B  in  32  ALU_Src mux output (rt or sign-extended immediate)
- imm_ext  in  32  sign-extended immediate
- pc_plus4  in  32  PC+4
- out_valid  out  1  registered in_valid
- ALUctrl  out  4  registered decoded operation
- JR_Signal  out  1  registered jump-register flag
- Alu_Result  out  32  registered ALU result
- Zero  out  1  registered flag, 1 when Alu_Result == 0
- branch_target  out  32  registered pc_plus4 + (imm_ext << 2)

## Operation
ALU_Op decode:
- 000 → ADD (lw/sw/addi)
- 001 → SUB (beq/bne)
- 010 → R-type, decoded from funct (see below)
- 011 → AND (andi)
- 100 → OR (ori)
- 101 → SLT (slti)
- 110 → LUI
- 111 → ADD

R-type funct decode:
- 100000 → ADD
- 100010 → SUB
- 100100 → AND
- 100101 → OR
- 100111 → NOR
- 101010 → SLT
- 000000 → SLL
- 000010 → SRL
- 001000 → JR; ALUctrl is ADD and JR_Signal is 1
- any other funct → ADD, with JR_Signal 0

JR_Signal is 1 only when ALU_Op == 010 and funct == 001000.

ALUctrl encodings:
- AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, LUI 0101, SUB 0110, SLT 0111, NOR 1100
- Any other code yields result 0.

ALU results:
- ADD: A + B, modulo 2^32, no overflow trap.
- SUB: A − B, modulo 2^32.
- AND, OR, NOR: bitwise on A and B.
- SLT: 1 if A < B as signed two's-complement, else 0.
- SLL: B << shamt.
- SRL: B >> shamt, logical (zero fill).
- LUI: {B[15:0], 16'h0000}.
- Zero is computed from the final result, for every operation.

Branch target: pc_plus4 + (imm_ext << 2), modulo 2^32. It is computed every cycle, regardless of opcode.

## Timing
- Decode, ALU and adder logic are combinational from the inputs.
- All outputs are registered on the rising edge of Clock, so latency is exactly 1 cycle.
- Throughput is one operation per cycle; there is no backpressure.
- Output registers capture on every edge, regardless of in_valid; out_valid qualifies them.
- Reset (Reset_n low): all outputs clear to 0, asynchronously. This includes out_valid, Alu_Result, branch_target, ALUctrl (the AND code) and JR_Signal. Zero also clears to 0 during reset.
- Deassertion of reset takes effect at the next rising edge.
- Reset asserted mid-stream discards the in-flight result.

## Structure
- Shared package holds:
  - the ALU_Op constants (3-bit);
  - the funct constants;
  - the ALUctrl encodings (4-bit).
- Submodule alu_decoder: combinational ALU_Op/funct → ALUctrl, JR_Signal.
- The ALU datapath, branch adder and output register live in the top level.

## Test plan
- ALU_Op=000, A=0x7FFFFFFF, B=1 → next cycle: Alu_Result=0x80000000, Zero=0. Then A=0xFFFFFFFF, B=1 → Alu_Result=0, Zero=1.
- ALU_Op=001, A=B=0x1234 → Alu_Result=0, Zero=1, ALUctrl=0110.
- ALU_Op=010 with funct sweep, A=0xF0F0F0F0, B=0x0FF00FF0, shamt=4:
  - AND → 0x00F000F0
  - OR → 0xFFF0FFF0
  - NOR → 0x000F000F
  - SLL → 0xFF00FF00
  - SRL → 0x00FF00FF
  - SLT → 1 (A is negative)
- ALU_Op=010, funct=001000 → JR_Signal=1, ALUctrl=0010. Same funct with ALU_Op=000 → JR_Signal=0.
- Branch adder:
  - pc_plus4=0x00400004, imm_ext=0xFFFFFFFF → branch_target=0x00400000.
  - imm_ext=0x00000010 → branch_target=0x00400044.
- Reset_n pulsed low mid-stream (between edges) → all outputs 0 immediately. First valid input after release appears one cycle later.
